seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, clocked successor to the combinational ALU select.
- Executes logic and add/sub ops in one cycle, and unsigned multiply/divide iteratively over WIDTH cycles.
- Uses a Start/Busy/Done handshake and drives registered LO/HI results plus flags.
- Sits in the EX stage; the control unit stalls the pipeline while Busy is high.

Parameters:
WIDTH, 32, operand/result width in bits; must be at least 4.
CNT_W, $clog2(WIDTH+1), iteration counter width; derived, never overridden.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
Start  input  1  request; sampled only when Busy=0
FunctC  input  4  operation code, captured with Start
A  input  WIDTH  operand A, captured with Start
B  input  WIDTH  operand B, captured with Start
Busy  output  1  operation in progress; Start ignored while high
Done  output  1  one-cycle pulse; result outputs valid from this cycle on
ALUOut  output  WIDTH  result / product low half / quotient
HiOut  output  WIDTH  product high half / remainder; 0 for other ops
Zero  output  1  ALUOut == 0
Overflow  output  1  signed overflow, add/sub only
DivByZero  output  1  divide with B == 0
IllegalOp  output  1  FunctC not in the op table

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; all outputs 0, including Zero.
  - Any in-flight operation is discarded with no Done.
  - The first rising clk after rst_n rises acts normally.
- Op table (FunctC):
  - 0010 add, 0110 sub, 0000 and, 0001 or, 0011 nor, 0100 xor: single-cycle.
  - 1010 mulu, 1111 divu: multi-cycle.
  - Any other code is illegal.
- States: IDLE, MUL, DIV.
  - IDLE + Start + single-cycle or illegal op: compute at edge E0; Done=1 for the cycle after E0; stay IDLE; Busy never rises.
  - IDLE + Start + mulu/divu: latch A, B, clear accumulators, set Busy at E0, go to MUL/DIV, counter = WIDTH.
  - MUL: shift-add one bit per edge.
  - DIV: restoring divide one bit per edge.
  - After edge E_WIDTH: counter hits 0, results and flags registered, Done=1, Busy=0, return to IDLE. Done-to-Start latency is WIDTH+1 edges including E0.
- Back-to-back: Start during the Done cycle is accepted (Busy=0 then).
- Start while Busy=1 is ignored; no queueing.
- Outputs hold their last values between Done pulses. Start=0 never alters them.
- Arithmetic rules:
  - add/sub: modulo 2^WIDTH.
  - Overflow = operand signs equal (add) or differ (sub) and result sign differs from A. Overflow=0 for all other ops.
  - mulu: unsigned WIDTH×WIDTH -> 2·WIDTH product; {HiOut, ALUOut} = product.
  - divu: unsigned; ALUOut = quotient, HiOut = remainder.
  - divu with B=0: no iteration; Done after E0 like a single-cycle op; ALUOut = all ones, HiOut = A, DivByZero=1.
  - Illegal op: ALUOut=0, HiOut=0, IllegalOp=1, Zero=1.
- Zero is registered alongside ALUOut, set and cleared on every Done; no latch.
- All flags are registered with the result and are valid only in or after the Done cycle.

Decomposition:
- Shared package alu_pkg holds:
  - FunctC localparams (OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_XOR, OP_MULU, OP_DIVU).
  - State enum {IDLE, MUL, DIV}.
- One sub-module, seq_muldiv_unit:
  - Inputs: load, mode, operands.
  - Outputs: lo, hi, done.
  - Owns the counter and shift registers.
- seq_alu keeps the op decode, single-cycle datapath, flag logic and handshake.

Test Plan:
- add 0x7FFFFFFF + 0x00000001 -> ALUOut 0x80000000, Overflow=1, Zero=0, Done one cycle after Start. Then sub 5−5 -> ALUOut 0, Zero=1, Overflow=0.
- mulu 0x00010000 × 0x00010000 -> ALUOut 0, HiOut 0x00000001, Zero=1. Done exactly 33 edges after the Start edge (E0..E32 inclusive); Busy high E0 through E31.
- divu 100 / 7 -> ALUOut 14, HiOut 2. Then divu 5 / 0 -> ALUOut 0xFFFFFFFF, HiOut 5, DivByZero=1, Done one cycle after Start.
- Start pulsed with xor while a divu is Busy -> ignored; divu result is correct. Start asserted in the divu Done cycle -> xor is accepted.
- rst_n dropped at divide iteration 10 -> outputs 0 immediately (async), no Done. Fresh mulu 3×4 after release -> ALUOut 12.
- FunctC=0101 -> IllegalOp=1, ALUOut 0, Zero=1. Repeat the product test with WIDTH=8: 0xFF×0xFF -> HiOut 0xFE, ALUOut 0x01, Done after 9 edges.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operation codes and controller states.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_MULU = 4'b1010;
    localparam logic [3:0] OP_DIVU = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_muldiv_unit.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one bit per clock.
// lo/hi/done are the values that will exist after the current edge, so the parent can register them.
module seq_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] breg;
    logic [WIDTH-1:0] hreg;
    logic [WIDTH-1:0] lreg;
    logic [WIDTH-1:0] hnext;
    logic [WIDTH-1:0] lnext;
    logic             mreg;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // Multiply keeps the product in {hreg, lreg} with the multiplier draining out of lreg;
    // divide keeps the partial remainder in hreg and shifts quotient bits into lreg.
    always_comb begin
        sum     = {1'b0, hreg} + (lreg[0] ? {1'b0, breg} : {(WIDTH + 1){1'b0}});
        shifted = {hreg, lreg[WIDTH-1]};
        trial   = shifted - {1'b0, breg};
        hnext   = hreg;
        lnext   = lreg;
        if (!mreg) begin
            hnext = sum[WIDTH:1];
            lnext = {sum[0], lreg[WIDTH-1:1]};
        end else if (!trial[WIDTH]) begin
            hnext = trial[WIDTH-1:0];
            lnext = {lreg[WIDTH-2:0], 1'b1};
        end else begin
            hnext = shifted[WIDTH-1:0];
            lnext = {lreg[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            breg <= '0;
            hreg <= '0;
            lreg <= '0;
            mreg <= 1'b0;
            cnt  <= '0;
        end else if (load) begin
            breg <= b;
            hreg <= '0;
            lreg <= a;
            mreg <= mode;
            cnt  <= CNT_W'(WIDTH);
        end else if (cnt != '0) begin
            hreg <= hnext;
            lreg <= lnext;
            cnt  <= cnt - CNT_W'(1);
        end
    end

    assign lo   = lnext;
    assign hi   = hnext;
    assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/seq_alu.sv
// Clocked EX-stage ALU: single-cycle logic/add/sub, iterative mulu/divu behind a Start/Busy/Done handshake.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [3:0]       FunctC,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ALUOut,
    output logic [WIDTH-1:0] HiOut,
    output logic             Zero,
    output logic             Overflow,
    output logic             DivByZero,
    output logic             IllegalOp
);

    state_t           state;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] sc_res;
    logic             sc_ovf;
    logic             sc_ill;
    logic             load;
    logic             mode;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] md_hi;
    logic             md_done;

    always_comb begin
        sum    = A + B;
        diff   = A - B;
        sc_res = '0;
        sc_ovf = 1'b0;
        sc_ill = 1'b0;
        case (FunctC)
            OP_ADD: begin
                sc_res = sum;
                sc_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = diff;
                sc_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:           sc_res = A & B;
            OP_OR:            sc_res = A | B;
            OP_NOR:           sc_res = ~(A | B);
            OP_XOR:           sc_res = A ^ B;
            OP_MULU, OP_DIVU: sc_res = '0;
            default:          sc_ill = 1'b1;
        endcase
    end

    // A zero divisor never enters the iterative unit; it completes like a single-cycle op.
    assign load = (state == IDLE) && Start &&
                  ((FunctC == OP_MULU) || ((FunctC == OP_DIVU) && (B != '0)));
    assign mode = (FunctC == OP_DIVU);

    seq_muldiv_unit #(.WIDTH(WIDTH)) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .mode  (mode),
        .a     (A),
        .b     (B),
        .lo    (md_lo),
        .hi    (md_hi),
        .done  (md_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            ALUOut    <= '0;
            HiOut     <= '0;
            Zero      <= 1'b0;
            Overflow  <= 1'b0;
            DivByZero <= 1'b0;
            IllegalOp <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        if (FunctC == OP_MULU) begin
                            state <= MUL;
                            Busy  <= 1'b1;
                        end else if (FunctC == OP_DIVU && B != '0) begin
                            state <= DIV;
                            Busy  <= 1'b1;
                        end else if (FunctC == OP_DIVU) begin
                            ALUOut    <= '1;
                            HiOut     <= A;
                            Zero      <= 1'b0;
                            Overflow  <= 1'b0;
                            DivByZero <= 1'b1;
                            IllegalOp <= 1'b0;
                            Done      <= 1'b1;
                        end else begin
                            ALUOut    <= sc_res;
                            HiOut     <= '0;
                            Zero      <= (sc_res == '0);
                            Overflow  <= sc_ovf;
                            DivByZero <= 1'b0;
                            IllegalOp <= sc_ill;
                            Done      <= 1'b1;
                        end
                    end
                end
                MUL, DIV: begin
                    if (md_done) begin
                        ALUOut    <= md_lo;
                        HiOut     <= md_hi;
                        Zero      <= (md_lo == '0);
                        Overflow  <= 1'b0;
                        DivByZero <= 1'b0;
                        IllegalOp <= 1'b0;
                        Done      <= 1'b1;
                        Busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Randomised self-checking bench for seq_alu against an arithmetic reference model (32- and 8-bit instances).
module tb_seq_alu;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Start, Start8;
    logic [3:0]  FunctC, FunctC8;
    logic [31:0] A, B, ALUOut, HiOut;
    logic [7:0]  A8, B8, ALUOut8, HiOut8;
    logic        Busy, Done, Zero, Overflow, DivByZero, IllegalOp;
    logic        Busy8, Done8, Zero8, Overflow8, DivByZero8, IllegalOp8;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .Start(Start), .FunctC(FunctC), .A(A), .B(B),
        .Busy(Busy), .Done(Done), .ALUOut(ALUOut), .HiOut(HiOut), .Zero(Zero),
        .Overflow(Overflow), .DivByZero(DivByZero), .IllegalOp(IllegalOp)
    );

    seq_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .Start(Start8), .FunctC(FunctC8), .A(A8), .B(B8),
        .Busy(Busy8), .Done(Done8), .ALUOut(ALUOut8), .HiOut(HiOut8), .Zero(Zero8),
        .Overflow(Overflow8), .DivByZero(DivByZero8), .IllegalOp(IllegalOp8)
    );

    // Reference: plain arithmetic on 64-bit values; fl = {Zero, Overflow, DivByZero, IllegalOp}.
    function automatic void model(input int w, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] lo, output logic [63:0] hi,
                                  output logic [3:0] fl, output int lat);
        logic [63:0] mask;
        logic ov, dz, il;
        mask = (64'd1 << w) - 64'd1;
        lo = 0; hi = 0; ov = 0; dz = 0; il = 0; lat = 1;
        case (op)
            OP_ADD: begin lo = (a + b) & mask; ov = (a[w-1] == b[w-1]) && (lo[w-1] != a[w-1]); end
            OP_SUB: begin lo = (a - b) & mask; ov = (a[w-1] != b[w-1]) && (lo[w-1] != a[w-1]); end
            OP_AND: lo = a & b;
            OP_OR:  lo = a | b;
            OP_NOR: lo = ~(a | b) & mask;
            OP_XOR: lo = a ^ b;
            OP_MULU: begin lo = (a * b) & mask; hi = ((a * b) >> w) & mask; lat = w + 1; end
            OP_DIVU: begin
                if (b == 0) begin lo = mask; hi = a; dz = 1; end
                else begin lo = a / b; hi = a % b; lat = w + 1; end
            end
            default: il = 1;
        endcase
        fl = {lo == 0, ov, dz, il};
    endfunction

    // Issues one Start, then counts edges (E0 = 1) until Done; counts samples where Busy disagrees.
    task automatic applyStimulus(input bit use8, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output int edges, output int busy_bad,
                                 output logic [31:0] lo, output logic [31:0] hi, output logic [3:0] fl);
        @(negedge clk);
        if (use8) begin Start8 = 1; FunctC8 = op; A8 = a[7:0]; B8 = b[7:0]; end
        else      begin Start  = 1; FunctC  = op; A  = a;      B  = b;      end
        @(posedge clk);
        edges = 1;
        busy_bad = 0;
        @(negedge clk);
        Start = 0;
        Start8 = 0;
        while (!(use8 ? Done8 : Done) && edges < 200) begin
            if (!(use8 ? Busy8 : Busy)) busy_bad++;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        if (use8 ? Busy8 : Busy) busy_bad++;
        lo = use8 ? {24'd0, ALUOut8} : ALUOut;
        hi = use8 ? {24'd0, HiOut8} : HiOut;
        fl = use8 ? {Zero8, Overflow8, DivByZero8, IllegalOp8} : {Zero, Overflow, DivByZero, IllegalOp};
    endtask

    task automatic test_reset();
        rst_n = 0; Start = 0; Start8 = 0; FunctC = 0; FunctC8 = 0; A = 0; B = 0; A8 = 0; B8 = 0;
        #12;
        checks++;
        if ({Busy, Done, ALUOut, HiOut, Zero, Overflow, DivByZero, IllegalOp} !== 70'd0)
            $display("[TB] FAIL reset32 got busy=%b done=%b lo=%h hi=%h flags=%b%b%b%b, expected all 0",
                     Busy, Done, ALUOut, HiOut, Zero, Overflow, DivByZero, IllegalOp);
        else passes++;
        checks++;
        if ({Busy8, Done8, ALUOut8, HiOut8, Zero8, Overflow8, DivByZero8, IllegalOp8} !== 22'd0)
            $display("[TB] FAIL reset8 got lo=%h hi=%h, expected all 0", ALUOut8, HiOut8);
        else passes++;
        @(negedge clk);
        rst_n = 1;
    endtask

    // Runs one directed op on the chosen instance and checks outputs, latency and Busy against the model.
    task automatic test_directed(input string name, input bit use8, input logic [3:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
        int edges, busy_bad, elat, w;
        logic [31:0] lo, hi;
        logic [3:0]  fl, efl;
        logic [63:0] elo, ehi;
        w = use8 ? 8 : 32;
        applyStimulus(use8, op, a, b, edges, busy_bad, lo, hi, fl);
        model(w, op, {32'd0, a}, {32'd0, b}, elo, ehi, efl, elat);
        checks++;
        if ({hi, lo, fl} !== {ehi[31:0], elo[31:0], efl})
            $display("[TB] FAIL %s result got hi=%h lo=%h flags=%b, expected hi=%h lo=%h flags=%b",
                     name, hi, lo, fl, ehi[31:0], elo[31:0], efl);
        else passes++;
        checks++;
        if (edges !== elat || busy_bad !== 0)
            $display("[TB] FAIL %s timing got edges=%0d busy_errors=%0d, expected edges=%0d busy_errors=0",
                     name, edges, busy_bad, elat);
        else passes++;
    endtask

    task automatic test_add_sub();
        test_directed("add_ovf", 0, OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
        test_directed("sub_zero", 0, OP_SUB, 32'd5, 32'd5);
    endtask

    task automatic test_mulu();
        test_directed("mulu_hi", 0, OP_MULU, 32'h0001_0000, 32'h0001_0000);
        test_directed("mulu8_ff", 1, OP_MULU, 32'hFF, 32'hFF);
    endtask

    task automatic test_divu();
        test_directed("divu_100_7", 0, OP_DIVU, 32'd100, 32'd7);
        test_directed("divu_by0", 0, OP_DIVU, 32'd5, 32'd0);
        test_directed("illegal", 0, 4'b0101, 32'h1234, 32'h5678);
    endtask

    task automatic test_hold();
        test_directed("hold_add", 0, OP_ADD, 32'd3, 32'd4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            A = $urandom; B = $urandom; FunctC = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        checks++;
        if (ALUOut !== 32'd7 || Done !== 1'b0 || HiOut !== 32'd0)
            $display("[TB] FAIL hold got lo=%h hi=%h done=%b, expected lo=7 hi=0 done=0", ALUOut, HiOut, Done);
        else passes++;
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        Start = 1; FunctC = OP_DIVU; A = 32'd1000; B = 32'd7;
        @(negedge clk);
        Start = 0;
        repeat (3) @(negedge clk);
        Start = 1; FunctC = OP_XOR; A = 32'hF0F0; B = 32'h0FF0;
        @(negedge clk);
        Start = 0;
        n = 0;
        while (!Done && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (Done !== 1'b1 || ALUOut !== 32'd142 || HiOut !== 32'd6)
            $display("[TB] FAIL busy_ignore got done=%b lo=%0d hi=%0d, expected done=1 lo=142 hi=6", Done, ALUOut, HiOut);
        else passes++;
        Start = 1; FunctC = OP_XOR; A = 32'hF0F0; B = 32'h0FF0;
        @(negedge clk);
        Start = 0;
        checks++;
        if (Done !== 1'b1 || ALUOut !== 32'hFF00 || Busy !== 1'b0)
            $display("[TB] FAIL b2b_xor got done=%b busy=%b lo=%h, expected done=1 busy=0 lo=0000ff00", Done, Busy, ALUOut);
        else passes++;
    endtask

    task automatic test_reset_midway();
        int done_seen;
        @(negedge clk);
        Start = 1; FunctC = OP_DIVU; A = 32'd1000; B = 32'd3;
        @(posedge clk);
        @(negedge clk);
        Start = 0;
        repeat (10) @(posedge clk);
        #2 rst_n = 0;
        #1;
        checks++;
        if ({Busy, Done, ALUOut, HiOut, Zero, Overflow, DivByZero, IllegalOp} !== 70'd0)
            $display("[TB] FAIL async_reset got busy=%b lo=%h hi=%h, expected all 0", Busy, ALUOut, HiOut);
        else passes++;
        repeat (2) @(negedge clk);
        rst_n = 1;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (Done || Busy) done_seen++;
        end
        checks++;
        if (done_seen !== 0)
            $display("[TB] FAIL reset_discard got %0d cycles with done/busy, expected 0", done_seen);
        else passes++;
        test_directed("mulu_after_reset", 0, OP_MULU, 32'd3, 32'd4);
    endtask

    task automatic test_random();
        logic [3:0] ops [8] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_XOR, OP_MULU, OP_DIVU};
        logic [3:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = ($urandom_range(0, 8) == 8) ? 4'($urandom_range(0, 15)) : ops[$urandom_range(0, 7)];
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if (op == OP_DIVU && $urandom_range(0, 1) == 1) b = $urandom_range(1, 1000);
            test_directed("random32", 0, op, a, b);
        end
        for (int i = 0; i < 12; i++) begin
            op = ops[$urandom_range(0, 7)];
            test_directed("random8", 1, op, $urandom_range(0, 255), $urandom_range(0, 255));
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mulu();
        test_divu();
        test_hold();
        test_back_to_back();
        test_reset_midway();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
